// File: rtl/input_port_buffer.sv
// Per-input-port flit buffer for a 5-port wormhole router: FIFO storage, XY routing of header
// flits and a one-hot direction request held toward flowcontrol for the whole packet.
module input_port_buffer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CUR_X      = 0,
  parameter int unsigned CUR_Y      = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  Nport,
  output logic                  Eport,
  output logic                  Wport,
  output logic                  Sport,
  output logic                  Lport,
  input  logic                  Nready,
  input  logic                  Eready,
  input  logic                  Wready,
  input  logic                  Sready,
  input  logic                  Lready,
  output logic                  drop_err
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam logic [AddrW:0] Full = (AddrW + 1)'(DEPTH);
  localparam logic [3:0] CurX = 4'(CUR_X);
  localparam logic [3:0] CurY = 4'(CUR_Y);
  localparam logic [1:0] TypeHeader = 2'b01;
  localparam logic [1:0] TypeTail   = 2'b10;

  typedef enum logic {StIdle, StSend} state_e;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AddrW-1:0]      r_wr_ptr;
  logic [AddrW-1:0]      r_rd_ptr;
  logic [AddrW:0]        r_count;
  state_e                r_state;
  logic [4:0]            r_port;  // {N, E, W, S, L}
  logic                  r_drop;

  logic [DATA_WIDTH-1:0] w_head;
  logic [1:0]            w_type;
  logic [3:0]            w_dx;
  logic [3:0]            w_dy;
  logic [4:0]            w_route;
  logic                  w_empty;
  logic                  w_valid;
  logic                  w_sel_ready;
  logic                  w_push;
  logic                  w_pop;

  assign w_head  = r_mem[r_rd_ptr];
  assign w_type  = w_head[DATA_WIDTH-1 -: 2];
  assign w_dx    = w_head[7:4];
  assign w_dy    = w_head[3:0];
  assign w_empty = (r_count == '0);

  // X dimension is resolved fully before Y.
  always_comb begin
    w_route = 5'b00001;
    if (w_dx > CurX)      w_route = 5'b01000;
    else if (w_dx < CurX) w_route = 5'b00100;
    else if (w_dy > CurY) w_route = 5'b10000;
    else if (w_dy < CurY) w_route = 5'b00010;
  end

  assign w_sel_ready = |(r_port & {Nready, Eready, Wready, Sready, Lready});
  assign w_valid     = (r_state == StSend) && !w_empty;
  assign w_push      = valid_in && ready_out;
  assign w_pop       = ((r_state == StIdle) && !w_empty && (w_type != TypeHeader)) ||
                       (w_valid && w_sel_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_state  <= StIdle;
      r_port   <= '0;
      r_drop   <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= data_in;
        r_wr_ptr        <= r_wr_ptr + AddrW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AddrW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AddrW + 1)'(1);
        2'b01:   r_count <= r_count - (AddrW + 1)'(1);
        default: r_count <= r_count;
      endcase
      r_drop <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (!w_empty) begin
            if (w_type == TypeHeader) begin
              r_port  <= w_route;
              r_state <= StSend;
            end else begin
              r_drop <= 1'b1;
            end
          end
        end
        StSend: begin
          // Only a tail closes the packet; stray headers pass through as body.
          if (w_pop && (w_type == TypeTail)) begin
            r_port  <= '0;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign ready_out = (r_count != Full);
  assign valid_out = w_valid;
  assign data_out  = w_valid ? w_head : '0;
  assign Nport     = r_port[4];
  assign Eport     = r_port[3];
  assign Wport     = r_port[2];
  assign Sport     = r_port[1];
  assign Lport     = r_port[0];
  assign drop_err  = r_drop;

endmodule

// File: tb/tb_input_port_buffer.sv
// Directed bench for input_port_buffer at CUR=(1,1), DEPTH=4; accepted flits are queued with
// their expected direction and checked against each observed transfer.
module tb_input_port_buffer;

  localparam logic [4:0] PN = 5'b10000;
  localparam logic [4:0] PE = 5'b01000;
  localparam logic [4:0] PW = 5'b00100;
  localparam logic [4:0] PS = 5'b00010;
  localparam logic [4:0] PL = 5'b00001;

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  p;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic        valid_in;
  logic        ready_out;
  logic [31:0] data_out;
  logic        valid_out;
  logic        Nport, Eport, Wport, Sport, Lport;
  logic        Nready, Eready, Wready, Sready, Lready;
  logic        drop_err;

  logic [4:0] w_pv;
  logic [4:0] w_rv;
  assign w_pv = {Nport, Eport, Wport, Sport, Lport};
  assign w_rv = {Nready, Eready, Wready, Sready, Lready};

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   xfers = 0;
  int   drops = 0;
  exp_t sb[$];
  int   xcyc[$];

  input_port_buffer #(
    .DATA_WIDTH(32),
    .DEPTH     (4),
    .CUR_X     (1),
    .CUR_Y     (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .data_out (data_out),
    .valid_out(valid_out),
    .Nport    (Nport),
    .Eport    (Eport),
    .Wport    (Wport),
    .Sport    (Sport),
    .Lport    (Lport),
    .Nready   (Nready),
    .Eready   (Eready),
    .Wready   (Wready),
    .Sready   (Sready),
    .Lready   (Lready),
    .drop_err (drop_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] hdr(input logic [3:0] x, input logic [3:0] y);
    return {2'b01, 22'h0, x, y};
  endfunction

  function automatic logic [31:0] body(input logic [29:0] v);
    return {2'b00, v};
  endfunction

  function automatic logic [31:0] tail(input logic [29:0] v);
    return {2'b10, v};
  endfunction

  // Transfer monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (drop_err === 1'b1) drops++;
    if (valid_out === 1'b1 && |(w_pv & w_rv)) begin
      xfers++;
      xcyc.push_back(cyc);
      if (sb.size() == 0) begin
        chk("spurious_xfer_sb_size", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("xfer_data", data_out, e.d);
        chk("xfer_port", 32'(w_pv), 32'(e.p));
      end
    end
  end

  // Drive a flit until accepted; queue it for checking unless it is expected to be dropped.
  task automatic push(input logic [31:0] d, input logic [4:0] p, input bit expect_out);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    data_in  = d;
    valid_in = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = (ready_out === 1'b1);
      @(posedge clk);
      #1;
      n++;
      if (acc && expect_out) sb.push_back('{d: d, p: p});
    end
    valid_in = 1'b0;
    if (!acc) chk("push_accept", 32'(acc), 32'd1);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({"drain_", tag}, 32'(sb.size()), 32'd0);
  endtask

  task automatic set_ready(input logic [4:0] r);
    {Nready, Eready, Wready, Sready, Lready} = r;
  endtask

  initial begin
    int xf0;
    int d0;
    rst      = 1'b1;
    data_in  = '0;
    valid_in = 1'b0;
    set_ready(5'b00000);

    // T1 reset
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready_out", 32'(ready_out), 32'd1);
    chk("rst_valid_out", 32'(valid_out), 32'd0);
    chk("rst_ports", 32'(w_pv), 32'd0);
    chk("rst_drop_err", 32'(drop_err), 32'd0);
    chk("rst_data_out", data_out, 32'd0);
    @(posedge clk);
    #1;

    // T2 east packet, three flits back to back
    set_ready(PE);
    xcyc.delete();
    push(hdr(4'd3, 4'd1), PE, 1'b1);
    push(body(30'h0AB), PE, 1'b1);
    push(tail(30'h0CD), PE, 1'b1);
    wait_drain("t2");
    @(negedge clk);
    chk("t2_eport_cleared", 32'(w_pv), 32'd0);
    chk("t2_xfer_count", 32'(xcyc.size()), 32'd3);
    if (xcyc.size() == 3) chk("t2_consecutive", 32'(xcyc[2] - xcyc[0]), 32'd2);
    @(posedge clk);
    #1;

    // T3 route table
    set_ready(5'b11111);
    push(hdr(4'd0, 4'd1), PW, 1'b1);
    push(tail(30'h1), PW, 1'b1);
    push(hdr(4'd1, 4'd2), PN, 1'b1);
    push(tail(30'h2), PN, 1'b1);
    push(hdr(4'd1, 4'd0), PS, 1'b1);
    push(tail(30'h3), PS, 1'b1);
    push(hdr(4'd1, 4'd1), PL, 1'b1);
    push(tail(30'h4), PL, 1'b1);
    push(hdr(4'd2, 4'd0), PE, 1'b1);
    push(tail(30'h5), PE, 1'b1);
    wait_drain("t3");

    // T4 backpressure on south, north ready toggling is irrelevant
    set_ready(5'b00000);
    push(hdr(4'd1, 4'd0), PS, 1'b1);
    push(body(30'h11), PS, 1'b1);
    push(body(30'h12), PS, 1'b1);
    push(body(30'h13), PS, 1'b1);
    @(negedge clk);
    chk("t4_full_ready_out", 32'(ready_out), 32'd0);
    xf0 = xfers;
    repeat (4) begin
      @(posedge clk);
      #1;
      Nready = ~Nready;
    end
    @(negedge clk);
    chk("t4_stall_no_xfer", 32'(xfers), 32'(xf0));
    chk("t4_still_full", 32'(ready_out), 32'd0);
    @(posedge clk);
    #1;
    Nready = 1'b0;
    Sready = 1'b1;
    @(negedge clk);
    chk("t4_ready_before_pop", 32'(ready_out), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t4_ready_after_pop", 32'(ready_out), 32'd1);
    @(posedge clk);
    #1;
    push(body(30'h14), PS, 1'b1);
    push(tail(30'h15), PS, 1'b1);
    wait_drain("t4");

    // T5 stray body flit while idle
    set_ready(5'b11111);
    d0  = drops;
    xf0 = xfers;
    push(32'h0000_0005, PL, 1'b0);
    repeat (4) begin
      @(negedge clk);
      chk("t5_no_port", 32'(w_pv), 32'd0);
    end
    chk("t5_drop_once", 32'(drops), 32'(d0 + 1));
    chk("t5_no_xfer", 32'(xfers), 32'(xf0));
    @(posedge clk);
    #1;

    // T6 reset mid-packet after two flits leave
    set_ready(5'b00000);
    push(hdr(4'd3, 4'd1), PE, 1'b1);
    push(body(30'h21), PE, 1'b1);
    push(body(30'h22), PE, 1'b1);
    push(tail(30'h23), PE, 1'b1);
    xf0 = xfers;
    Eready = 1'b1;
    begin
      int n;
      n = 0;
      while (xfers < xf0 + 2 && n < 50) begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    Eready = 1'b0;
    chk("t6_two_sent", 32'(xfers), 32'(xf0 + 2));
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_ready_out", 32'(ready_out), 32'd1);
    chk("t6_valid_out", 32'(valid_out), 32'd0);
    chk("t6_ports", 32'(w_pv), 32'd0);
    @(posedge clk);
    #1;
    Nready = 1'b1;
    push(hdr(4'd1, 4'd2), PN, 1'b1);
    push(tail(30'h31), PN, 1'b1);
    wait_drain("t6");
    @(negedge clk);
    chk("t6_ports_cleared", 32'(w_pv), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
